// File: rtl/vram_pkg.sv
// Shared types and width defaults for the VRAM initiator-side arbiter.
package vram_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RDATA,
        DONE
    } arb_state_e;

endpackage

// File: rtl/vram_arb_if.sv
// Signal bundle between the video fetch, host register path and the VRAM port.
interface vram_arb_if #(
    parameter int ADDR_W = vram_pkg::VRAM_ADDR_W,
    parameter int DATA_W = vram_pkg::VRAM_DATA_W
);
    logic              vid_sel;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_data_out;

    logic              host_req;
    logic              host_wr;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data_in;
    logic              host_busy;
    logic              host_ack;
    logic [DATA_W-1:0] host_data_out;

    logic              vram_sel;
    logic              vram_wr_en;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_data_in;
    logic [DATA_W-1:0] vram_data_out;

    // Arbiter view.
    modport slave (
        input  vid_sel, vid_addr,
        input  host_req, host_wr, host_addr, host_data_in,
        input  vram_data_out,
        output vid_valid, vid_data_out,
        output host_busy, host_ack, host_data_out,
        output vram_sel, vram_wr_en, vram_addr, vram_data_in
    );

    // Surrounding system view: fetch logic, host interface and the VRAM itself.
    modport master (
        output vid_sel, vid_addr,
        output host_req, host_wr, host_addr, host_data_in,
        output vram_data_out,
        input  vid_valid, vid_data_out,
        input  host_busy, host_ack, host_data_out,
        input  vram_sel, vram_wr_en, vram_addr, vram_data_in
    );

endinterface

// File: rtl/vram_arb.sv
// VRAM port arbiter: video reads always win, a single held host request
// takes the first cycle with no video access.
module vram_arb
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic       clk,
    input  logic       reset,
    vram_arb_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic              hold_wr_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [DATA_W-1:0] hold_data_q;
    logic              vid_valid_q;
    logic [DATA_W-1:0] host_data_out_q;
    logic              grant;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            IDLE:    if (bus.host_req) state_d = PEND;
            PEND: begin
                if (!bus.vid_sel) begin
                    grant   = 1'b1;
                    state_d = hold_wr_q ? DONE : RDATA;
                end
            end
            RDATA:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            hold_wr_q       <= 1'b0;
            hold_addr_q     <= '0;
            hold_data_q     <= '0;
            vid_valid_q     <= 1'b0;
            host_data_out_q <= '0;
        end else begin
            state_q     <= state_d;
            vid_valid_q <= bus.vid_sel;
            if (state_q == IDLE && bus.host_req) begin
                hold_wr_q   <= bus.host_wr;
                hold_addr_q <= bus.host_addr;
                hold_data_q <= bus.host_data_in;
            end
            // Data for a host read lands here; a grant only happens with vid_sel low, so no video return collides.
            if (state_q == RDATA) host_data_out_q <= bus.vram_data_out;
        end
    end

    always_comb begin
        bus.vram_sel     = bus.vid_sel | grant;
        bus.vram_addr    = bus.vid_sel ? bus.vid_addr : hold_addr_q;
        // A write granted in a reset cycle must never reach the array.
        bus.vram_wr_en   = grant & hold_wr_q & ~reset;
        bus.vram_data_in = hold_data_q;
    end

    assign bus.host_busy     = (state_q != IDLE);
    assign bus.host_ack      = (state_q == DONE);
    assign bus.host_data_out = host_data_out_q;
    assign bus.vid_valid     = vid_valid_q;
    assign bus.vid_data_out  = bus.vram_data_out;

endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: behavioural VRAM, reference memory and
// scoreboards for video returns and host completions.
module tb_vram_arb;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } host_txn_t;

    logic clk;
    logic reset;

    vram_arb_if bus ();

    vram_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] vram_mem [0:65535];
    logic [15:0] ref_mem  [0:65535];
    logic [15:0] vram_rdata;

    logic [15:0] vid_q [$];
    host_txn_t   host_q [$];
    logic [15:0] vid_exp;
    host_txn_t   txn;

    int total;
    int passed;
    int ack_count;

    // Behavioural VRAM: one-cycle read latency, write on the selected edge.
    always @(posedge clk) begin
        if (bus.vram_sel === 1'b1) begin
            if (bus.vram_wr_en === 1'b1) vram_mem[bus.vram_addr] <= bus.vram_data_in;
            else                         vram_rdata <= vram_mem[bus.vram_addr];
        end
    end
    assign bus.vram_data_out = vram_rdata;

    // Return-side scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.vid_valid === 1'b1) begin
            total++;
            if (vid_q.size() == 0) begin
                $display("FAIL vid_unexpected: vid_valid=1 with no pending video read, data %h", bus.vid_data_out);
            end else begin
                vid_exp = vid_q.pop_front();
                if (bus.vid_data_out !== vid_exp)
                    $display("FAIL vid_data: got %h expected %h", bus.vid_data_out, vid_exp);
                else
                    passed++;
            end
        end
        if (bus.host_ack === 1'b1) begin
            ack_count++;
            total++;
            if (host_q.size() == 0) begin
                $display("FAIL host_ack_unexpected: host_ack=1 with no pending host request");
            end else begin
                txn = host_q.pop_front();
                if (txn.wr) begin
                    ref_mem[txn.addr] = txn.data;
                    passed++;
                end else if (bus.host_data_out !== ref_mem[txn.addr]) begin
                    $display("FAIL host_rdata: addr %h got %h expected %h",
                             txn.addr, bus.host_data_out, ref_mem[txn.addr]);
                end else begin
                    passed++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vid(input logic sel, input logic [15:0] addr);
        bus.vid_sel  = sel;
        bus.vid_addr = addr;
        if (sel) vid_q.push_back(ref_mem[addr]);
    endtask

    // Presents a host request for one cycle; records it only if it will be accepted.
    task automatic host_issue(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        bus.host_req     = 1'b1;
        bus.host_wr      = wr;
        bus.host_addr    = addr;
        bus.host_data_in = data;
        if (bus.host_busy === 1'b0) host_q.push_back('{wr: wr, addr: addr, data: data});
        step();
        bus.host_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.host_busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        total++;
        if (bus.host_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.host_busy);
        else passed++;
        total++;
        if (bus.host_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", bus.host_ack);
        else passed++;
        total++;
        if (bus.host_data_out !== 16'h0000) $display("FAIL reset_hdata: got %h expected 0000", bus.host_data_out);
        else passed++;
        total++;
        if (bus.vid_valid !== 1'b0) $display("FAIL reset_vid_valid: got %b expected 0", bus.vid_valid);
        else passed++;
        total++;
        if (bus.vram_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", bus.vram_wr_en);
        else passed++;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_uncontended_write();
        bit ok;
        bus.host_req     = 1'b1;
        bus.host_wr      = 1'b1;
        bus.host_addr    = 16'h1234;
        bus.host_data_in = 16'hBEEF;
        host_q.push_back('{wr: 1'b1, addr: 16'h1234, data: 16'hBEEF});
        @(negedge clk);
        total++;
        if (bus.host_busy !== 1'b0) $display("FAIL wr_busy_T: got %b expected 0", bus.host_busy);
        else passed++;
        step();
        bus.host_req = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.host_busy, bus.vram_sel, bus.vram_wr_en, bus.vram_addr, bus.vram_data_in} !==
            {1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF})
            $display("FAIL wr_grant_T1: busy/sel/wr_en/addr/data got %b/%b/%b/%h/%h expected 1/1/1/1234/beef",
                     bus.host_busy, bus.vram_sel, bus.vram_wr_en, bus.vram_addr, bus.vram_data_in);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if (bus.host_ack !== 1'b1) $display("FAIL wr_ack_T2: got %b expected 1", bus.host_ack);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if (bus.host_busy !== 1'b0) $display("FAIL wr_busy_T3: got %b expected 0", bus.host_busy);
        else passed++;
        step();
        host_issue(1'b0, 16'h1234, 16'h0000);
        wait_idle(20, ok);
        total++;
        if (!ok) $display("FAIL wr_readback_timeout: busy still 1 expected 0");
        else passed++;
        total++;
        if (bus.host_data_out !== 16'hBEEF) $display("FAIL wr_readback: got %h expected beef", bus.host_data_out);
        else passed++;
    endtask

    task automatic test_contended_read();
        bus.host_req     = 1'b1;
        bus.host_wr      = 1'b0;
        bus.host_addr    = 16'h0040;
        bus.host_data_in = 16'h0000;
        host_q.push_back('{wr: 1'b0, addr: 16'h0040, data: 16'h0000});
        step();
        bus.host_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_vid(1'b1, 16'h0100 + 16'(i));
            @(negedge clk);
            total++;
            if ({bus.host_busy, bus.vram_wr_en, bus.vram_addr} !== {1'b1, 1'b0, 16'h0100 + 16'(i)})
                $display("FAIL contend_no_grant_%0d: busy/wr_en/addr got %b/%b/%h expected 1/0/%h",
                         i, bus.host_busy, bus.vram_wr_en, bus.vram_addr, 16'h0100 + 16'(i));
            else passed++;
            step();
        end
        drive_vid(1'b0, 16'h0000);
        @(negedge clk);
        total++;
        if ({bus.vram_sel, bus.vram_wr_en, bus.vram_addr} !== {1'b1, 1'b0, 16'h0040})
            $display("FAIL contend_grant: sel/wr_en/addr got %b/%b/%h expected 1/0/0040",
                     bus.vram_sel, bus.vram_wr_en, bus.vram_addr);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if (bus.host_ack !== 1'b0) $display("FAIL contend_early_ack: got %b expected 0", bus.host_ack);
        else passed++;
        step();
        @(negedge clk);
        total++;
        if ({bus.host_ack, bus.host_data_out} !== {1'b1, 16'h1357})
            $display("FAIL contend_ack: ack/data got %b/%h expected 1/1357", bus.host_ack, bus.host_data_out);
        else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        int misses;
        int acks_before;
        bit ok;
        misses      = 0;
        acks_before = ack_count;
        for (int i = 0; i < 256; i++) begin
            drive_vid(1'b1, 16'(i));
            if (i == 0) begin
                bus.host_req     = 1'b1;
                bus.host_wr      = 1'b0;
                bus.host_addr    = 16'h0600;
                bus.host_data_in = 16'h0000;
                host_q.push_back('{wr: 1'b0, addr: 16'h0600, data: 16'h0000});
            end
            @(negedge clk);
            if (i > 0 && bus.vid_valid !== 1'b1) misses++;
            step();
            bus.host_req = 1'b0;
        end
        drive_vid(1'b0, 16'h0000);
        @(negedge clk);
        if (bus.vid_valid !== 1'b1) misses++;
        total++;
        if (misses != 0) $display("FAIL b2b_vid_valid: %0d cycles without vid_valid expected 0", misses);
        else passed++;
        total++;
        if (ack_count != acks_before) $display("FAIL b2b_no_ack: %0d acks expected 0", ack_count - acks_before);
        else passed++;
        step();
        wait_idle(20, ok);
        total++;
        if (!ok) $display("FAIL b2b_host_timeout: busy still 1 expected 0");
        else passed++;
    endtask

    task automatic test_busy_ignore();
        int acks_before;
        bit ok;
        acks_before = ack_count;
        host_issue(1'b1, 16'h0010, 16'h1111);
        host_issue(1'b1, 16'h0002, 16'h5555);
        wait_idle(20, ok);
        step();
        total++;
        if (!ok || ack_count - acks_before != 1)
            $display("FAIL busy_ignore_acks: ok=%b acks %0d expected 1", ok, ack_count - acks_before);
        else passed++;
        host_issue(1'b0, 16'h0002, 16'h0000);
        wait_idle(20, ok);
        total++;
        if (bus.host_data_out !== 16'h0202)
            $display("FAIL busy_ignore_target: got %h expected 0202", bus.host_data_out);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int acks_before;
        bit wr_seen;
        bit ok;
        wr_seen = 1'b0;
        drive_vid(1'b1, 16'h0700);
        host_issue(1'b1, 16'h0300, 16'hDEAD);
        for (int i = 0; i < 3; i++) begin
            drive_vid(1'b1, 16'h0700 + 16'(i));
            @(negedge clk);
            if (bus.vram_wr_en !== 1'b0) wr_seen = 1'b1;
            step();
        end
        drive_vid(1'b0, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (bus.vram_wr_en !== 1'b0) $display("FAIL rst_mid_wr_en: got %b expected 0", bus.vram_wr_en);
        else passed++;
        step();
        reset = 1'b0;
        host_q.delete();
        acks_before = ack_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.vram_wr_en !== 1'b0) wr_seen = 1'b1;
            step();
        end
        total++;
        if ({wr_seen, bus.host_busy} !== 2'b00 || ack_count != acks_before)
            $display("FAIL rst_mid_quiet: wr_seen/busy/acks got %b/%b/%0d expected 0/0/0",
                     wr_seen, bus.host_busy, ack_count - acks_before);
        else passed++;
        host_issue(1'b0, 16'h0300, 16'h0000);
        wait_idle(20, ok);
        total++;
        if (bus.host_data_out !== 16'h0303)
            $display("FAIL rst_mid_target: got %h expected 0303", bus.host_data_out);
        else passed++;
    endtask

    task automatic test_read_hold();
        int acks_before;
        bit ok;
        host_issue(1'b0, 16'h0500, 16'h0000);
        wait_idle(20, ok);
        total++;
        if (bus.host_data_out !== 16'hA5A5) $display("FAIL hold_read: got %h expected a5a5", bus.host_data_out);
        else passed++;
        acks_before = ack_count;
        host_issue(1'b1, 16'h0501, 16'h0F0F);
        wait_idle(20, ok);
        total++;
        if (ack_count - acks_before != 1 || bus.host_data_out !== 16'hA5A5)
            $display("FAIL hold_after_write: acks %0d data %h expected 1 a5a5",
                     ack_count - acks_before, bus.host_data_out);
        else passed++;
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        ack_count    = 0;
        reset        = 1'b1;
        bus.vid_sel  = 1'b0;
        bus.vid_addr = '0;
        bus.host_req = 1'b0;
        bus.host_wr  = 1'b0;
        bus.host_addr    = '0;
        bus.host_data_in = '0;
        for (int i = 0; i < 65536; i++) begin
            vram_mem[i] <= i[15:0] ^ 16'h5AC3;
            ref_mem[i]   = i[15:0] ^ 16'h5AC3;
        end
        vram_mem[16'h0040] <= 16'h1357;  ref_mem[16'h0040] = 16'h1357;
        vram_mem[16'h0002] <= 16'h0202;  ref_mem[16'h0002] = 16'h0202;
        vram_mem[16'h0300] <= 16'h0303;  ref_mem[16'h0300] = 16'h0303;
        vram_mem[16'h0500] <= 16'hA5A5;  ref_mem[16'h0500] = 16'hA5A5;

        test_reset();
        test_uncontended_write();
        test_contended_read();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_op();
        test_read_hold();

        step();
        step();
        total++;
        if (vid_q.size() != 0 || host_q.size() != 0)
            $display("FAIL drain: %0d video and %0d host results outstanding expected 0",
                     vid_q.size(), host_q.size());
        else passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vram_arb.md
# vram_arb

Initiator-side arbiter for the 64K×16 VRAM port: merges the video fetch read stream and a single-entry host read/write request path onto the one VRAM sel/wr_en/address/data interface. Video has absolute priority and is never stalled; the host request waits in a holding register until a cycle with no video access. The block sits between the video timing/fetch logic, the host register interface, and the VRAM instance. It also returns read data to whichever side issued the read.

## Interface
- ADDR_W, 16, VRAM word address width
- DATA_W, 16, VRAM data width
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- vid_sel  in  1  video read request this cycle (single-cycle, may be asserted every cycle)
- vid_addr  in  ADDR_W  video read address
- vid_valid  out  1  video read data valid (vid_sel delayed one cycle)
- vid_data_out  out  DATA_W  video read data, equal to vram_data_out
- host_req  in  1  host request strobe, sampled only when host_busy=0
- host_wr  in  1  1=write, 0=read, sampled with host_req
- host_addr  in  ADDR_W  host address, sampled with host_req
- host_data_in  in  DATA_W  host write data, sampled with host_req
- host_busy  out  1  request held or in flight
- host_ack  out  1  one-cycle completion pulse
- host_data_out  out  DATA_W  registered host read data, valid when host_ack=1 and held until next read completes
- vram_sel  out  1  VRAM access this cycle
- vram_wr_en  out  1  VRAM write enable
- vram_addr  out  ADDR_W  VRAM address
- vram_data_in  out  DATA_W  VRAM write data
- vram_data_out  in  DATA_W  VRAM read data, valid one cycle after vram_sel with vram_wr_en=0

## Operation
- States: IDLE, PEND (request held, waiting for slot), RDATA (host read issued, data returning), DONE (ack cycle).
- IDLE: host_req=1 → capture host_wr/addr/data_in into hold regs, → PEND.
- PEND: vid_sel=1 → stay PEND, VRAM driven by video. vid_sel=0 → host granted this cycle; write → DONE; read → RDATA.
- RDATA: host_data_out <= vram_data_out; → DONE.
- DONE: host_ack=1; → IDLE.
- VRAM mux (combinational): vram_sel = vid_sel | grant; vram_addr = vid_sel ? vid_addr : hold_addr; vram_wr_en = grant & hold_wr & ~reset; vram_data_in = hold_data.
- grant = (state==PEND) & ~vid_sel.
- host_busy = (state != IDLE).
- vid_valid registered from vid_sel. Host and video reads never overlap in the return cycle because a grant happens only when vid_sel=0.
- host_req while host_busy=1 is ignored. No queueing beyond one entry.
- Reset mid-operation: state → IDLE and held request discarded. No ack and no write are issued. A write granted in the reset cycle is suppressed.

## Timing
- Reset values: state IDLE, host_busy 0, host_ack 0, host_data_out 0, vid_valid 0. vram_wr_en is 0 during reset.
- Host request accepted at cycle T → host_busy=1 from T+1 and PEND at T+1.
- Uncontended write: grant at T+1, ack at T+2, busy=0 at T+3. A new request may be presented at T+3.
- Uncontended read: grant at T+1, capture at end of T+2, ack plus valid host_data_out at T+3, busy=0 at T+4.
- Each cycle of vid_sel=1 in PEND delays the grant by exactly one cycle. There is no starvation bound, and video may block the host indefinitely.
- Video latency is fixed: vid_sel at N → vid_valid and vid_data_out at N+1, regardless of host state.

## Structure
- Shared package vram_pkg: the state enum (IDLE, PEND, RDATA, DONE) and the ADDR_W/DATA_W defaults.
- No sub-module. The single always_ff holds the state, hold regs, vid_valid and host_data_out. A separate always_comb holds the VRAM mux. The VRAM itself is instantiated by the parent.

## Test plan
- Uncontended write: req wr addr=0x1234 data=0xBEEF, vid_sel=0 → vram_wr_en=1 with addr 0x1234 and data 0xBEEF at T+1, ack at T+2, and a later read of 0x1234 returns 0xBEEF.
- Contended read: vid_sel=1 for 5 cycles after a host read req of 0x0040 → no host grant during those cycles. The grant occurs on the first vid_sel=0 cycle, and the ack with correct data comes 2 cycles later. Every video read meanwhile gets vid_valid with correct data.
- Back-to-back: continuous vid_sel=1 with video reads of 0x0000..0x00FF, preloaded pattern → vid_valid every cycle, data matches, and host_ack is never pulsed.
- Busy ignore: second host_req (wr 0x0002=0x5555) while busy → only the first request executes, and 0x0002 keeps its prior value.
- Reset mid-op: host write held in PEND with vid_sel=1, then reset for 1 cycle → vram_wr_en never asserts, no host_ack, and the target address is unchanged.
- Read-data hold: host read returns 0xA5A5, followed by a host write → host_data_out remains 0xA5A5 after the write ack.
